// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, types and helpers for the timing generator and frame-buffer controller.
// No logic; pure definitions.
package vga_timing_pkg;

    localparam int CNT_W   = 10;
    localparam int FRAME_W = 8;
    localparam int RGB_W   = 6;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

    localparam int CHECKER_CELL = 40;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [RGB_W-1:0] rgb_t;

    localparam rgb_t FG_RGB_DEF = 6'b111111;
    localparam rgb_t BG_RGB_DEF = 6'b000000;

    // Raw timing flags as they travel down the delay line; all-zero means blank with sync deasserted.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_t;

    function automatic logic in_window(cnt_t x, int first, int last);
        return (int'(x) >= first) && (int'(x) <= last);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-counter / colour exchange with the frame-buffer controller plus the VGA pin outputs.
// master = timing generator, slave = consumer (controller side / pins).
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    cnt_t                counter_H;
    cnt_t                counter_V;
    logic                frame_tick;
    logic [FRAME_W-1:0]  frame_cnt;
    logic                colour;
    logic                vga_hsync;
    logic                vga_vsync;
    rgb_t                vga_rgb;

    modport master (
        output counter_H, counter_V, frame_tick, frame_cnt,
        output vga_hsync, vga_vsync, vga_rgb,
        input  colour
    );

    modport slave (
        input  counter_H, counter_V, frame_tick, frame_cnt,
        input  vga_hsync, vga_vsync, vga_rgb,
        output colour
    );

endinterface

// File: rtl/vga_pipe_delay.sv
// Purpose: DEPTH-stage, W-bit shift register with synchronous active-low clear to all-zero.
// Latency: DEPTH cycles. Backpressure: none, advances every cycle.
module vga_pipe_delay #(
    parameter int W     = 3,
    parameter int DEPTH = 3
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: free-running VGA timing generator, blanked RGB + syncs; VGA_TEST_PATTERN_EN swaps colour for a 40x40 checkerboard.
// Latency: counters registered; pins lag counters by PIPE_DELAY+1 cycles.
// Backpressure: none, one pixel per clk unconditionally.
module vga_timing_gen #(
    parameter int                   H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int                   H_FP       = vga_timing_pkg::H_FP,
    parameter int                   H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int                   H_BP       = vga_timing_pkg::H_BP,
    parameter int                   V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int                   V_FP       = vga_timing_pkg::V_FP,
    parameter int                   V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int                   V_BP       = vga_timing_pkg::V_BP,
    parameter bit                   SYNC_POL   = 1'b0,
    parameter int                   PIPE_DELAY = 3,
    parameter vga_timing_pkg::rgb_t FG_RGB     = vga_timing_pkg::FG_RGB_DEF,
    parameter vga_timing_pkg::rgb_t BG_RGB     = vga_timing_pkg::BG_RGB_DEF
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  bus
);
    import vga_timing_pkg::*;

    localparam int H_LAST = H_ACTIVE + H_FP + H_SYNC + H_BP - 1;
    localparam int V_LAST = V_ACTIVE + V_FP + V_SYNC + V_BP - 1;
    localparam int HS_LO  = H_ACTIVE + H_FP;
    localparam int HS_HI  = HS_LO + H_SYNC - 1;
    localparam int VS_LO  = V_ACTIVE + V_FP;
    localparam int VS_HI  = VS_LO + V_SYNC - 1;

    cnt_t               h_q;
    cnt_t               v_q;
    logic               tick_q;
    logic [FRAME_W-1:0] frame_q;
    logic               h_wrap;
    logic               v_wrap;

    assign h_wrap = (int'(h_q) == H_LAST);
    assign v_wrap = (int'(v_q) == V_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_q     <= '0;
            v_q     <= '0;
            tick_q  <= 1'b0;
            frame_q <= '0;
        end else begin
            h_q <= h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) v_q <= v_wrap ? '0 : v_q + 1'b1;
            // Only a genuine end-of-frame wrap ticks; the (0,0) coming out of reset does not.
            tick_q <= h_wrap && v_wrap;
            if (h_wrap && v_wrap) frame_q <= frame_q + 1'b1;
        end
    end

    sync_t raw;
    sync_t dly;
    logic  pix;

    always_comb begin
        raw     = '0;
        raw.hs  = in_window(h_q, HS_LO, HS_HI);
        raw.vs  = in_window(v_q, VS_LO, VS_HI);
        raw.act = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam cnt_t CELL = cnt_t'(CHECKER_CELL);

    cnt_t       h_cell;
    cnt_t       v_cell;
    logic       pat_raw;
    logic       pat_d;
    logic [3:0] dly_bits;

    assign h_cell  = h_q / CELL;
    assign v_cell  = v_q / CELL;
    assign pat_raw = h_cell[0] ^ v_cell[0];

    // Pattern rides the same delay line as act so it lines up exactly like colour would.
    vga_pipe_delay #(.W(4), .DEPTH(PIPE_DELAY)) u_dly (
        .clk   (clk),
        .clr_n (reset),
        .din   ({raw, pat_raw}),
        .dout  (dly_bits)
    );
    assign {dly, pat_d} = dly_bits;
    assign pix          = pat_d;
`else
    logic [2:0] dly_bits;

    vga_pipe_delay #(.W(3), .DEPTH(PIPE_DELAY)) u_dly (
        .clk   (clk),
        .clr_n (reset),
        .din   (raw),
        .dout  (dly_bits)
    );
    assign dly = dly_bits;
    assign pix = bus.colour;
`endif

    logic hs_q;
    logic vs_q;
    rgb_t rgb_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            rgb_q <= '0;
        end else begin
            hs_q  <= dly.hs ? SYNC_POL : ~SYNC_POL;
            vs_q  <= dly.vs ? SYNC_POL : ~SYNC_POL;
            // The blanking mux selects on act first, so an unknown colour in blanking never propagates.
            rgb_q <= dly.act ? (pix ? FG_RGB : BG_RGB) : '0;
        end
    end

    assign bus.counter_H  = h_q;
    assign bus.counter_V  = v_q;
    assign bus.frame_tick = tick_q;
    assign bus.frame_cnt  = frame_q;
    assign bus.vga_hsync  = hs_q;
    assign bus.vga_vsync  = vs_q;
    assign bus.vga_rgb    = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance and a tiny-geometry instance checked every cycle against an arithmetic model.
module tb_vga_timing_gen;

    typedef struct packed {
        int         ha, hf, hs, hb, va, vf, vs, vb, pd;
        bit         pol;
        logic [5:0] fg, bg;
    } geo_t;

    localparam geo_t G_DEF = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, pd:3,
                               pol:1'b0, fg:6'h3f, bg:6'h00};
    localparam geo_t G_SM  = '{ha:8, hf:2, hs:3, hb:3, va:6, vf:1, vs:2, vb:2, pd:1,
                               pol:1'b1, fg:6'h2a, bg:6'h15};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_timing_gen_if if_def ();
    vga_timing_gen_if if_sm ();

    vga_timing_gen #(
        .H_ACTIVE(G_DEF.ha), .H_FP(G_DEF.hf), .H_SYNC(G_DEF.hs), .H_BP(G_DEF.hb),
        .V_ACTIVE(G_DEF.va), .V_FP(G_DEF.vf), .V_SYNC(G_DEF.vs), .V_BP(G_DEF.vb),
        .SYNC_POL(G_DEF.pol), .PIPE_DELAY(G_DEF.pd), .FG_RGB(G_DEF.fg), .BG_RGB(G_DEF.bg)
    ) u_def (.clk(clk), .reset(reset), .bus(if_def));

    vga_timing_gen #(
        .H_ACTIVE(G_SM.ha), .H_FP(G_SM.hf), .H_SYNC(G_SM.hs), .H_BP(G_SM.hb),
        .V_ACTIVE(G_SM.va), .V_FP(G_SM.vf), .V_SYNC(G_SM.vs), .V_BP(G_SM.vb),
        .SYNC_POL(G_SM.pol), .PIPE_DELAY(G_SM.pd), .FG_RGB(G_SM.fg), .BG_RGB(G_SM.bg)
    ) u_sm (.clk(clk), .reset(reset), .bus(if_sm));

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    bit   stop   = 1'b0;
    bit   armed  = 1'b0;
    bit   mid_done;
    int   k_m    = 0;
    logic lc_def, lc_sm;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s at k=%0d: got %h, expected %h", name, k_m, got, exp);
            if (n_fail > 50) stop = 1'b1;
        end
    endtask

    function automatic bit pix_active(geo_t g, int p);
        int ht, vt;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;
        if (p < 0) return 1'b0;
        return ((p % ht) < g.ha) && (((p / ht) % vt) < g.va);
    endfunction

    // Expected {H, V, tick, frame_cnt, hsync, vsync, rgb} for cycle k after reset release.
    function automatic logic [36:0] expect_out(geo_t g, int k, logic col);
        int ht, vt, ft, p, ph, pv;
        logic [9:0] h, v;
        logic       tick, hs, vs, c;
        logic [7:0] fc;
        logic [5:0] rgb;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;
        ft = ht * vt;
        h    = 10'(k % ht);
        v    = 10'((k / ht) % vt);
        tick = (k > 0) && (k % ft == 0);
        fc   = 8'((k / ft) % 256);
        hs   = ~g.pol;
        vs   = ~g.pol;
        rgb  = '0;
        p    = k - g.pd - 1;
        if (p >= 0) begin
            ph = p % ht;
            pv = (p / ht) % vt;
            if (ph >= g.ha + g.hf && ph < g.ha + g.hf + g.hs) hs = g.pol;
            if (pv >= g.va + g.vf && pv < g.va + g.vf + g.vs) vs = g.pol;
`ifdef VGA_TEST_PATTERN_EN
            c = (((ph / 40) ^ (pv / 40)) & 1) == 1;
`else
            c = col;
`endif
            if (ph < g.ha && pv < g.va) rgb = c ? g.fg : g.bg;
        end
        return {h, v, tick, fc, hs, vs, rgb};
    endfunction

    function automatic logic pick_colour(geo_t g, int k);
        bit phase1;
        phase1 = !mid_done && (k < 1600);
        if (!pix_active(g, k - g.pd)) begin
            if (phase1 || $urandom_range(1) == 1) return 1'bx;
            return 1'b0;
        end
        if (phase1) return 1'b1;
        return 1'($urandom_range(1));
    endfunction

    // Model time base: k counts posedges with reset high since the last reset.
    always @(posedge clk) begin
        lc_def = if_def.colour;
        lc_sm  = if_sm.colour;
        if (!reset) begin
            k_m   = 0;
            armed = 1'b1;
        end else begin
            k_m = k_m + 1;
        end
    end

    always @(negedge clk) begin
        if (armed && !stop) begin
            chk("def_outputs",
                {if_def.counter_H, if_def.counter_V, if_def.frame_tick, if_def.frame_cnt,
                 if_def.vga_hsync, if_def.vga_vsync, if_def.vga_rgb},
                expect_out(G_DEF, k_m, lc_def));
            chk("sm_outputs",
                {if_sm.counter_H, if_sm.counter_V, if_sm.frame_tick, if_sm.frame_cnt,
                 if_sm.vga_hsync, if_sm.vga_vsync, if_sm.vga_rgb},
                expect_out(G_SM, k_m, lc_sm));
            if (k_m == 0) chk("reset_state", {if_def.counter_H, if_def.counter_V, if_def.frame_cnt,
                                              if_def.vga_hsync, if_def.vga_vsync, if_def.vga_rgb},
                              {10'd0, 10'd0, 8'd0, 1'b1, 1'b1, 6'd0});
            if (k_m == 799) chk("h_last", if_def.counter_H, 10'd799);
            if (k_m == 800) chk("line_wrap", {if_def.counter_H, if_def.counter_V}, {10'd0, 10'd1});
            if (k_m == 659) chk("hs_before", if_def.vga_hsync, 1'b1);
            if (k_m == 660) chk("hs_first", if_def.vga_hsync, 1'b0);
            if (k_m == 755) chk("hs_last", if_def.vga_hsync, 1'b0);
            if (k_m == 756) chk("hs_after", if_def.vga_hsync, 1'b1);
            if (k_m == 644) chk("rgb_hblank", if_def.vga_rgb, 6'h00);
`ifdef VGA_TEST_PATTERN_EN
            if (k_m == 4)  chk("pat_px0", if_def.vga_rgb, 6'h00);
            if (k_m == 44) chk("pat_px40", if_def.vga_rgb, 6'h3f);
`else
            if (k_m == 3 && !mid_done) chk("rgb_pre_latency", if_def.vga_rgb, 6'h00);
            if (k_m == 4 && !mid_done) chk("rgb_first_px", if_def.vga_rgb, 6'h3f);
`endif
            if (k_m == 11)    chk("sm_hs_before", if_sm.vga_hsync, 1'b0);
            if (k_m == 12)    chk("sm_hs_first", if_sm.vga_hsync, 1'b1);
            if (k_m == 113)   chk("sm_vs_before", if_sm.vga_vsync, 1'b0);
            if (k_m == 114)   chk("sm_vs_first", if_sm.vga_vsync, 1'b1);
            if (k_m == 145)   chk("sm_vs_last", if_sm.vga_vsync, 1'b1);
            if (k_m == 146)   chk("sm_vs_after", if_sm.vga_vsync, 1'b0);
            if (k_m == 175)   chk("sm_fc_before", if_sm.frame_cnt, 8'd0);
            if (k_m == 176)   chk("sm_frame_wrap", {if_sm.frame_tick, if_sm.frame_cnt}, {1'b1, 8'd1});
            if (k_m == 177)   chk("sm_tick_once", if_sm.frame_tick, 1'b0);
            if (k_m == 45055) chk("sm_fc_255", if_sm.frame_cnt, 8'd255);
            if (k_m == 45056) chk("sm_fc_wrap", if_sm.frame_cnt, 8'd0);
        end
    end

    initial begin
        reset         = 1'b0;
        mid_done      = 1'b0;
        if_def.colour = 1'b0;
        if_sm.colour  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 60000; c++) begin
            @(posedge clk);
            #1;
            if (stop) break;
            // Mid-frame reset while the full-size instance sits at (300,3).
            if (!mid_done && k_m == 2700) begin
                reset    = 1'b0;
                mid_done = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #1 reset = 1'b1;
            end
            if_def.colour = pick_colour(G_DEF, k_m);
            if_sm.colour  = pick_colour(G_SM, k_m);
            if (mid_done && k_m > 45300) break;
        end
        if (!mid_done || k_m < 45057) chk("run_length", 64'(k_m), 64'd45057);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
